// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// multicycle_ctrl : main control FSM of the multicycle RV32I core.
// Optional SYSTEM/CSR path enabled by `MULTICYCLE_CSR_EN.  Rev 1.0
// ============================================================================
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_we,
  output logic       pc_we,
  output logic       reg_we,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       csr_we,
  output logic       illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
`ifdef MULTICYCLE_CSR_EN
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
`endif

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    EXEC_R    = 4'd3,
    EXEC_I    = 4'd4,
    LUI       = 4'd5,
    MEM_ADDR  = 4'd6,
    MEM_RD    = 4'd7,
    MEM_WR    = 4'd8,
    WB_MEM    = 4'd9,
    WB_ALU    = 4'd10,
    BRANCH    = 4'd11,
    JALR_ADDR = 4'd12,
    JUMP      = 4'd13
`ifdef MULTICYCLE_CSR_EN
    ,
    SYS       = 4'd14
`endif
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       pc_we;
    logic       reg_we;
`ifdef MULTICYCLE_CSR_EN
    logic       csr_we;
`endif
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
  } ctrl_t;

  state_t state;
  state_t nxt;
  ctrl_t  ctrl;
  logic   fetch_done;

  function automatic state_t next_of(input state_t s, input logic go,
                                     input logic [6:0] op, input logic rdy);
    state_t n;
    n = IDLE;
    case (s)
      IDLE:      n = go  ? FETCH  : IDLE;
      FETCH:     n = rdy ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_R:                n = EXEC_R;
          OP_I:                n = EXEC_I;
          OP_LOAD, OP_STORE:   n = MEM_ADDR;
          OP_BRANCH:           n = BRANCH;
          OP_JAL:              n = JUMP;
          OP_JALR:             n = JALR_ADDR;
          OP_LUI:              n = LUI;
          OP_AUIPC:            n = WB_ALU;
`ifdef MULTICYCLE_CSR_EN
          OP_SYSTEM:           n = SYS;
`endif
          default:             n = FETCH;
        endcase
      end
      EXEC_R, EXEC_I, LUI: n = WB_ALU;
      MEM_ADDR:  n = (op == OP_LOAD) ? MEM_RD : MEM_WR;
      MEM_RD:    n = rdy ? WB_MEM : MEM_RD;
      MEM_WR:    n = rdy ? FETCH  : MEM_WR;
      JALR_ADDR: n = JUMP;
      JUMP:      n = WB_ALU;
      WB_MEM, WB_ALU, BRANCH: n = FETCH;
`ifdef MULTICYCLE_CSR_EN
      SYS:       n = FETCH;
`endif
      default:   n = IDLE;
    endcase
    return n;
  endfunction

  // State-only controls; registered alongside the state they belong to.
  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_req    = 1'b1;
        c.alu_src_a  = 2'b10;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      EXEC_R:  c.alu_op = 2'b10;
      EXEC_I: begin
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      LUI: begin
        c.alu_src_a = 2'b11;
        c.alu_src_b = 2'b01;
      end
      MEM_ADDR, JALR_ADDR: c.alu_src_b = 2'b01;
      MEM_RD: begin
        c.mem_req = 1'b1;
        c.adr_src = 1'b1;
      end
      MEM_WR: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.adr_src = 1'b1;
      end
      WB_MEM: begin
        c.reg_we     = 1'b1;
        c.result_src = 2'b01;
      end
      WB_ALU:  c.reg_we = 1'b1;
      BRANCH:  c.alu_op = 2'b01;
      JUMP: begin
        c.pc_we     = 1'b1;
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
      end
`ifdef MULTICYCLE_CSR_EN
      SYS: begin
        c.csr_we     = 1'b1;
        c.reg_we     = 1'b1;
        c.result_src = 2'b11;
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb nxt = next_of(state, en, opcode, mem_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ctrl  <= '0;
    end else begin
      state <= nxt;
      ctrl  <= ctrl_of(nxt);
    end
  end

  assign fetch_done = (state == FETCH) && mem_ready;

  assign mem_req    = ctrl.mem_req;
  assign mem_we     = ctrl.mem_we;
  assign adr_src    = ctrl.adr_src;
  assign ir_we      = fetch_done;
  assign pc_we      = ctrl.pc_we | fetch_done | ((state == BRANCH) && branch_taken);
  assign reg_we     = ctrl.reg_we;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign result_src = ctrl.result_src;
  // Every supported opcode leaves DECODE somewhere other than FETCH.
  assign illegal    = (state == DECODE) && (nxt == FETCH);
`ifdef MULTICYCLE_CSR_EN
  assign csr_we     = ctrl.csr_we;
`else
  assign csr_we     = 1'b0;
`endif

endmodule
`default_nettype wire
